// File: rtl/safe_sync_pkg.sv
// Shared types and constants for the dual-core rendezvous (safe sync) block.
package safe_sync_pkg;

    localparam int unsigned NumCores = 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT0,
        WAIT1,
        IRQ,
        TOUT,
        RELEASE
    } sync_state_e;

endpackage

// File: rtl/safe_sync_edge_det.sv
// Rising-edge detector: registered history, combinational rise = in & ~prev.
module safe_sync_edge_det #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] in_i,
    output logic [Width-1:0] rise_o
);

    logic [Width-1:0] prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= '0;
        end else begin
            prev_q <= in_i;
        end
    end

    assign rise_o = in_i & ~prev_q;

endmodule

// File: rtl/safe_sync_fsm.sv
// Dual-core rendezvous FSM: pairs core sync requests within a bounded window,
// raises the sync IRQ until acknowledged, flags sticky timeouts, counts syncs.
module safe_sync_fsm
    import safe_sync_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned CntWidth      = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                core0sync_i,
    input  logic                core1sync_i,
    input  logic                intc_ack_i,
    output logic [NumCores-1:0] sync_irq_o,
    output logic                sync_done_o,
    output logic                timeout_o,
    output logic                busy_o,
    output logic [CntWidth-1:0] sync_cnt_o
);

    localparam int unsigned TimerW = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
    localparam logic [TimerW-1:0]   TimerLoad = TimerW'(TimeoutCycles);
    localparam logic [TimerW-1:0]   TimerOne  = TimerW'(1);
    localparam logic [CntWidth-1:0] CntOne    = CntWidth'(1);

    sync_state_e         state_q;
    logic [TimerW-1:0]   timer_q;
    logic [NumCores-1:0] irq_q;
    logic                done_q;
    logic                timeout_q;
    logic                busy_q;
    logic                from_irq_q;
    logic [CntWidth-1:0] cnt_q;

    // rise[0] = core0, rise[1] = core1, rise[2] = ack
    logic [2:0] rise;
    logic       go_irq;

    safe_sync_edge_det #(
        .Width(3)
    ) u_edge (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .in_i  ({intc_ack_i, core1sync_i, core0sync_i}),
        .rise_o(rise)
    );

    // Partner arrival outranks timer expiry, so IRQ entry is resolved first.
    always_comb begin
        go_irq = 1'b0;
        case (state_q)
            IDLE:    go_irq = rise[0] & rise[1];
            WAIT0:   go_irq = rise[0];
            WAIT1:   go_irq = rise[1];
            default: go_irq = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            irq_q      <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
            from_irq_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            done_q <= 1'b0;
            if (go_irq) begin
                state_q   <= IRQ;
                irq_q     <= '1;
                cnt_q     <= cnt_q + CntOne;
                timeout_q <= 1'b0;
                busy_q    <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rise[0]) begin
                            state_q <= WAIT1;
                            timer_q <= TimerLoad;
                            busy_q  <= 1'b1;
                        end else if (rise[1]) begin
                            state_q <= WAIT0;
                            timer_q <= TimerLoad;
                            busy_q  <= 1'b1;
                        end
                    end
                    WAIT0, WAIT1: begin
                        if (TimeoutCycles != 0) begin
                            if (timer_q == TimerOne) begin
                                state_q   <= TOUT;
                                timeout_q <= 1'b1;
                            end else begin
                                timer_q <= timer_q - TimerOne;
                            end
                        end
                    end
                    IRQ: begin
                        if (rise[2]) begin
                            state_q    <= RELEASE;
                            irq_q      <= '0;
                            from_irq_q <= 1'b1;
                        end
                    end
                    TOUT: begin
                        if (rise[2]) begin
                            state_q    <= RELEASE;
                            from_irq_q <= 1'b0;
                        end
                    end
                    RELEASE: begin
                        if (!core0sync_i && !core1sync_i && !intc_ack_i) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= from_irq_q;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sync_irq_o  = irq_q;
    assign sync_done_o = done_q;
    assign timeout_o   = timeout_q;
    assign busy_o      = busy_q;
    assign sync_cnt_o  = cnt_q;

endmodule

// File: tb/tb_safe_sync_fsm.sv
// Directed self-checking bench for safe_sync_fsm (TimeoutCycles=8, CntWidth=4).
module tb_safe_sync_fsm;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       core0sync_i = 1'b0;
    logic       core1sync_i = 1'b0;
    logic       intc_ack_i = 1'b0;
    logic [1:0] sync_irq_o;
    logic       sync_done_o;
    logic       timeout_o;
    logic       busy_o;
    logic [3:0] sync_cnt_o;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    safe_sync_fsm #(
        .TimeoutCycles(8),
        .CntWidth(4)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .core0sync_i(core0sync_i),
        .core1sync_i(core1sync_i),
        .intc_ack_i (intc_ack_i),
        .sync_irq_o (sync_irq_o),
        .sync_done_o(sync_done_o),
        .timeout_o  (timeout_o),
        .busy_o     (busy_o),
        .sync_cnt_o (sync_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Stimulus only: ack an IRQ/TOUT, then clear all registers back to IDLE.
    task automatic do_release();
        intc_ack_i = 1'b1;
        tick();
        core0sync_i = 1'b0;
        core1sync_i = 1'b0;
        intc_ack_i  = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) tick();
        total++; if (sync_irq_o !== 2'b00) begin bad++; $display("FAIL reset_irq got=%b exp=00", sync_irq_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        total++; if (sync_cnt_o !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", sync_cnt_o); end
        total++; if ({sync_done_o, timeout_o} !== 2'b00) begin bad++; $display("FAIL reset_done_tout got=%b exp=00", {sync_done_o, timeout_o}); end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        core0sync_i = 1'b1;
        tick();
        total++; if ({busy_o, sync_irq_o} !== 3'b100) begin bad++; $display("FAIL basic_wait got=%b exp=100", {busy_o, sync_irq_o}); end
        repeat (4) tick();
        core1sync_i = 1'b1;
        tick();
        exp_cnt++;
        total++; if (sync_irq_o !== 2'b11) begin bad++; $display("FAIL basic_irq got=%b exp=11", sync_irq_o); end
        total++; if (sync_cnt_o !== 4'(exp_cnt)) begin bad++; $display("FAIL basic_cnt got=%0d exp=%0d", sync_cnt_o, exp_cnt % 16); end
        repeat (4) tick();
        total++; if (sync_irq_o !== 2'b11) begin bad++; $display("FAIL basic_irq_hold got=%b exp=11", sync_irq_o); end
        intc_ack_i = 1'b1;
        tick();
        total++; if ({busy_o, sync_irq_o, sync_done_o} !== 4'b1000) begin bad++; $display("FAIL basic_ack got=%b exp=1000", {busy_o, sync_irq_o, sync_done_o}); end
        repeat (4) tick();
        core0sync_i = 1'b0;
        core1sync_i = 1'b0;
        intc_ack_i  = 1'b0;
        tick();
        total++; if ({sync_done_o, busy_o} !== 2'b10) begin bad++; $display("FAIL basic_done got=%b exp=10", {sync_done_o, busy_o}); end
        tick();
        total++; if (sync_done_o !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", sync_done_o); end
    endtask

    task automatic test_timeout();
        core1sync_i = 1'b1;
        tick();
        repeat (7) tick();
        total++; if ({timeout_o, busy_o} !== 2'b01) begin bad++; $display("FAIL tout_early got=%b exp=01", {timeout_o, busy_o}); end
        tick();
        total++; if ({timeout_o, sync_irq_o} !== 3'b100) begin bad++; $display("FAIL tout_set got=%b exp=100", {timeout_o, sync_irq_o}); end
        intc_ack_i = 1'b1;
        tick();
        total++; if ({timeout_o, busy_o, sync_irq_o} !== 4'b1100) begin bad++; $display("FAIL tout_release got=%b exp=1100", {timeout_o, busy_o, sync_irq_o}); end
        core1sync_i = 1'b0;
        intc_ack_i  = 1'b0;
        tick();
        total++; if ({timeout_o, busy_o, sync_done_o} !== 3'b100) begin bad++; $display("FAIL tout_idle got=%b exp=100", {timeout_o, busy_o, sync_done_o}); end
        tick();
        total++; if ({sync_done_o, sync_cnt_o} !== {1'b0, 4'(exp_cnt)}) begin bad++; $display("FAIL tout_nodone got=%b/%0d exp=0/%0d", sync_done_o, sync_cnt_o, exp_cnt % 16); end
    endtask

    task automatic test_boundary();
        core0sync_i = 1'b1;
        tick();
        repeat (7) tick();
        total++; if ({timeout_o, busy_o} !== 2'b11) begin bad++; $display("FAIL bound_sticky got=%b exp=11", {timeout_o, busy_o}); end
        core1sync_i = 1'b1;
        tick();
        exp_cnt++;
        total++; if ({sync_irq_o, timeout_o} !== 3'b110) begin bad++; $display("FAIL bound_partner_wins got=%b exp=110", {sync_irq_o, timeout_o}); end
        total++; if (sync_cnt_o !== 4'(exp_cnt)) begin bad++; $display("FAIL bound_cnt got=%0d exp=%0d", sync_cnt_o, exp_cnt % 16); end
        intc_ack_i = 1'b1;
        tick();
        core0sync_i = 1'b0;
        core1sync_i = 1'b0;
        intc_ack_i  = 1'b0;
        tick();
        total++; if (sync_done_o !== 1'b1) begin bad++; $display("FAIL bound_done got=%b exp=1", sync_done_o); end
        tick();
    endtask

    task automatic test_same_cycle();
        core0sync_i = 1'b1;
        core1sync_i = 1'b1;
        tick();
        exp_cnt++;
        total++; if (sync_irq_o !== 2'b11) begin bad++; $display("FAIL same_irq got=%b exp=11", sync_irq_o); end
        core0sync_i = 1'b0;
        tick();
        core0sync_i = 1'b1;
        tick();
        tick();
        total++; if ({sync_irq_o, sync_cnt_o} !== {2'b11, 4'(exp_cnt)}) begin bad++; $display("FAIL same_toggle got=%b/%0d exp=11/%0d", sync_irq_o, sync_cnt_o, exp_cnt % 16); end
        do_release();
    endtask

    task automatic test_wrap();
        while (exp_cnt < 15) begin
            core0sync_i = 1'b1;
            core1sync_i = 1'b1;
            tick();
            exp_cnt++;
            do_release();
        end
        total++; if (sync_cnt_o !== 4'd15) begin bad++; $display("FAIL wrap_pre got=%0d exp=15", sync_cnt_o); end
        core0sync_i = 1'b1;
        core1sync_i = 1'b1;
        tick();
        exp_cnt++;
        total++; if ({sync_irq_o, sync_cnt_o} !== {2'b11, 4'd0}) begin bad++; $display("FAIL wrap_zero got=%b/%0d exp=11/0", sync_irq_o, sync_cnt_o); end
        do_release();
    endtask

    task automatic test_async_reset();
        core0sync_i = 1'b1;
        core1sync_i = 1'b1;
        tick();
        total++; if (sync_irq_o !== 2'b11) begin bad++; $display("FAIL areset_pre got=%b exp=11", sync_irq_o); end
        #2;
        rst_i = 1'b1;
        core1sync_i = 1'b0;
        #1;
        total++; if ({sync_irq_o, busy_o, sync_cnt_o} !== 7'b0) begin bad++; $display("FAIL areset_now got=%b exp=0000000", {sync_irq_o, busy_o, sync_cnt_o}); end
        exp_cnt = 0;
        tick();
        rst_i = 1'b0;
        tick();
        total++; if ({busy_o, sync_irq_o} !== 3'b100) begin bad++; $display("FAIL areset_wait1 got=%b exp=100", {busy_o, sync_irq_o}); end
        core1sync_i = 1'b1;
        tick();
        exp_cnt++;
        total++; if ({sync_irq_o, sync_cnt_o} !== {2'b11, 4'(exp_cnt)}) begin bad++; $display("FAIL areset_irq got=%b/%0d exp=11/%0d", sync_irq_o, sync_cnt_o, exp_cnt); end
        do_release();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_boundary();
        test_same_cycle();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
